// File: rtl/parking_pkg.sv
// Shared types and state encodings for the car-park lane arbiter, its sensor decoder and bench.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IN  = 2'd1,
    GRANT_OUT = 2'd2,
    HOLD      = 2'd3
  } lane_state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT_IN  = 2'd1;
  localparam logic [1:0] ST_GRANT_OUT = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

endpackage

// File: rtl/parking_grant_timer.sv
// Grant lifetime counter: cleared when a grant starts, counts while a grant is held.
module parking_grant_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] r_timer;

  // Saturates at TIMEOUT-1 so expiry stays asserted until the grant ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable && !o_expired) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_expired = (r_timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/parking_lane_arbiter.sv
// Single-lane entry/exit arbiter that owns the occupancy count.
// Optional grant timeout is compiled in when PARKING_TIMEOUT_EN is defined.
module parking_lane_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY = 10,
  parameter int unsigned COUNT_W  = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic               inc_pulse,
  input  logic               dec_pulse,
  output logic               entry_grant,
  output logic               exit_grant,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               timeout_evt,
  output logic               err_unexpected,
  output logic [1:0]         state_dbg
);

  logic [1:0]         r_state, w_state_nxt;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  dir_t               r_last_dir, w_last_dir_nxt;
  logic               r_err, w_err_nxt;
  logic               r_timeout_evt, w_timeout_nxt;
  logic               w_entry_elig, w_exit_elig;
  logic               w_grant_start, w_in_grant, w_expired;

  assign w_entry_elig = entry_req && !full;
  assign w_exit_elig  = exit_req && !empty;
  assign w_in_grant   = (r_state == ST_GRANT_IN) || (r_state == ST_GRANT_OUT);

`ifdef PARKING_TIMEOUT_EN
  parking_grant_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_clear   (w_grant_start),
    .i_enable  (w_in_grant),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_last_dir_nxt = r_last_dir;
    w_err_nxt      = r_err;
    w_timeout_nxt  = 1'b0;
    w_grant_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inc_pulse || dec_pulse) w_err_nxt = 1'b1;
        // On a tie, serve the direction opposite the last grant.
        if (w_entry_elig && (!w_exit_elig || r_last_dir == DIR_OUT)) begin
          w_state_nxt    = ST_GRANT_IN;
          w_last_dir_nxt = DIR_IN;
          w_grant_start  = 1'b1;
        end else if (w_exit_elig) begin
          w_state_nxt    = ST_GRANT_OUT;
          w_last_dir_nxt = DIR_OUT;
          w_grant_start  = 1'b1;
        end
      end
      ST_GRANT_IN: begin
        if (dec_pulse) w_err_nxt = 1'b1;
        if (inc_pulse) begin
          if (r_count == COUNT_W'(CAPACITY)) w_err_nxt = 1'b1;
          else w_count_nxt = r_count + 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_HOLD;
        end
      end
      ST_GRANT_OUT: begin
        if (inc_pulse) w_err_nxt = 1'b1;
        if (dec_pulse) begin
          if (r_count == '0) w_err_nxt = 1'b1;
          else w_count_nxt = r_count - 1'b1;
          w_state_nxt = ST_HOLD;
        end else if (w_expired) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_HOLD;
        end
      end
      default: begin
        if (inc_pulse || dec_pulse) w_err_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_last_dir    <= DIR_OUT;
      r_err         <= 1'b0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_last_dir    <= w_last_dir_nxt;
      r_err         <= w_err_nxt;
      r_timeout_evt <= w_timeout_nxt;
    end
  end

  assign entry_grant    = (r_state == ST_GRANT_IN);
  assign exit_grant     = (r_state == ST_GRANT_OUT);
  assign count          = r_count;
  assign full           = (r_count == COUNT_W'(CAPACITY));
  assign empty          = (r_count == '0);
  assign timeout_evt    = r_timeout_evt;
  assign err_unexpected = r_err;
  assign state_dbg      = r_state;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Directed bench for parking_lane_arbiter; covers the timeout path when PARKING_TIMEOUT_EN is set.
module tb_parking_lane_arbiter;
  import parking_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       inc_pulse = 1'b0;
  logic       dec_pulse = 1'b0;
  logic       entry_grant, exit_grant, full, empty, timeout_evt, err_unexpected;
  logic [3:0] count;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_lane_arbiter #(
    .CAPACITY (10),
    .COUNT_W  (4),
    .TIMEOUT  (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry_req      (entry_req),
    .exit_req       (exit_req),
    .inc_pulse      (inc_pulse),
    .dec_pulse      (dec_pulse),
    .entry_grant    (entry_grant),
    .exit_grant     (exit_grant),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .timeout_evt    (timeout_evt),
    .err_unexpected (err_unexpected),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_entry();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    tick();
  endtask

  task automatic do_exit();
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    dec_pulse = 1'b1;
    tick();
    dec_pulse = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_grants", {entry_grant, exit_grant}, 0);
    check("rst_err_to", {err_unexpected, timeout_evt}, 0);
    #5 reset = 1'b1;
    tick();

    // Basic entry, completion three cycles after the grant
    entry_req = 1'b1;
    tick();
    check("t1_grant", entry_grant, 1);
    check("t1_state", state_dbg, ST_GRANT_IN);
    entry_req = 1'b0;
    tick();
    tick();
    check("t1_grant_held", entry_grant, 1);
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    check("t1_count", count, 1);
    check("t1_hold", state_dbg, ST_HOLD);
    check("t1_grant_low", entry_grant, 0);
    check("t1_empty", empty, 0);
    tick();
    check("t1_idle", state_dbg, ST_IDLE);

    // Fill to capacity, then entry blocked until an exit frees a space
    for (int i = 0; i < 9; i++) do_entry();
    check("t2_count10", count, 10);
    check("t2_full", full, 1);
    entry_req = 1'b1;
    tick();
    tick();
    check("t2_no_entry", {entry_grant, state_dbg}, {1'b0, ST_IDLE});
    exit_req = 1'b1;
    tick();
    check("t2_exit_grant", exit_grant, 1);
    exit_req = 1'b0;
    dec_pulse = 1'b1;
    tick();
    dec_pulse = 1'b0;
    check("t2_count9", count, 9);
    check("t2_not_full", full, 0);
    tick();
    check("t2_idle", state_dbg, ST_IDLE);
    tick();
    check("t2_entry_now", entry_grant, 1);
    entry_req = 1'b0;
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    tick();
    check("t2_back10", count, 10);

    // Round-robin with both requests held; last grant was OUT-preceding-IN so bring last_dir to OUT
    for (int i = 0; i < 5; i++) do_exit();
    check("t3_count5", count, 5);
    entry_req = 1'b1;
    exit_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("t3_grant_in", {entry_grant, exit_grant}, 2'b10);
        inc_pulse = 1'b1;
      end else begin
        check("t3_grant_out", {entry_grant, exit_grant}, 2'b01);
        dec_pulse = 1'b1;
      end
      tick();
      inc_pulse = 1'b0;
      dec_pulse = 1'b0;
      check("t3_hold", state_dbg, ST_HOLD);
      check("t3_count", count, (i % 2 == 0) ? 6 : 5);
      tick();
    end
    entry_req = 1'b0;
    exit_req = 1'b0;
    check("t3_no_err", err_unexpected, 0);

    // Grant with no completion pulse
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("t4_grant_first", entry_grant, 1);
    for (int i = 1; i < 64; i++) begin
      tick();
      check("t4_grant_held", {entry_grant, timeout_evt}, 2'b10);
    end
    tick();
`ifdef PARKING_TIMEOUT_EN
    check("t4_grant_drop", entry_grant, 0);
    check("t4_timeout_evt", timeout_evt, 1);
    check("t4_hold", state_dbg, ST_HOLD);
    check("t4_count", count, 5);
    tick();
    check("t4_evt_once", timeout_evt, 0);
    check("t4_idle", state_dbg, ST_IDLE);
`else
    check("t4_grant_persists", entry_grant, 1);
    check("t4_no_timeout", timeout_evt, 0);
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    check("t4_count6", count, 6);
    tick();
    do_exit();
    check("t4_count5", count, 5);
`endif

    // Wrong-direction pulse during a grant, then a pulse in IDLE
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    check("t5_err_clear", err_unexpected, 0);
    dec_pulse = 1'b1;
    tick();
    dec_pulse = 1'b0;
    check("t5_err_set", err_unexpected, 1);
    check("t5_count_same", count, 5);
    check("t5_still_grant", state_dbg, ST_GRANT_IN);
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    tick();
    check("t5_count6", count, 6);
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    check("t5_idle_pulse_count", count, 6);
    check("t5_err_sticky", err_unexpected, 1);

    // Reset in the middle of an exit grant
    tick();
    do_entry();
    check("t6_count7", count, 7);
    exit_req = 1'b1;
    tick();
    check("t6_exit_grant", exit_grant, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_grant_drop", exit_grant, 0);
    check("t6_count0", count, 0);
    check("t6_state", state_dbg, ST_IDLE);
    check("t6_err_cleared", err_unexpected, 0);
    exit_req = 1'b0;
    #10 reset = 1'b1;
    tick();
    check("t6_after_release", {state_dbg, empty}, {ST_IDLE, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
